// File: rtl/fetch_align_unit_pkg.sv
// Shared definitions for the RV32IC fetch/align front end: FSM states,
// queue geometry, reset PC default and the compressed-instruction test.
package fetch_align_unit_pkg;

  typedef enum logic {
    ST_RUN,
    ST_DROP
  } state_t;

  localparam int unsigned QUEUE_DEPTH      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, PC redirect
// and the instruction handoff to the IF/ID register.
interface fetch_align_unit_if;

  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_compressed;

  modport master (
    output fetch_req, fetch_addr, inst_valid, inst_data, inst_pc, inst_compressed,
    input  fetch_gnt, fetch_valid, fetch_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  fetch_req, fetch_addr, inst_valid, inst_data, inst_pc, inst_compressed,
    output fetch_gnt, fetch_valid, fetch_data, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_align_unit_halfword_queue.sv
// Circular buffer of 16-bit instruction parcels; accepts 0/1/2 pushes and
// 0/1/2 pops per cycle. clear empties it and overrides every other request.
module halfword_queue
  import fetch_align_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push1,
  input  logic        push2,
  input  logic        pop1,
  input  logic        pop2,
  input  logic [15:0] push_lo,
  input  logic [15:0] push_hi,
  output logic [15:0] head0,
  output logic [15:0] head1,
  output logic [2:0]  count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

  logic [15:0]      mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [2:0]       pushed;
  logic [2:0]       popped;

  always_comb begin
    pushed = 3'd0;
    popped = 3'd0;
    if (push2)     pushed = 3'd2;
    else if (push1) pushed = 3'd1;
    if (pop2)      popped = 3'd2;
    else if (pop1) popped = 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(popped);
      tail  <= tail + PTR_W'(pushed);
      count <= count + pushed - popped;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push1 || push2) mem[tail] <= push_lo;
      if (push2)          mem[tail + PTR_W'(1)] <= push_hi;
    end
  end

  assign head0 = mem[head];
  assign head1 = mem[head + PTR_W'(1)];

endmodule

// File: rtl/fetch_align_unit.sv
// RV32IC fetch front end: word fetches into a halfword queue, extraction of
// 16/32-bit instructions (including word-straddling ones) and PC redirect.
module fetch_align_unit
  import fetch_align_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic               clk,
  input logic               rst,
  fetch_align_unit_if.master bus
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] fetch_addr_q;
  logic [31:0] head_pc_q;
  logic        outstanding_q;
  logic        skip_lo_q;

  logic        fetch_req;
  logic        accept;
  logic        resp;
  logic        push1;
  logic        push2;
  logic        pop1;
  logic        pop2;
  logic        head_comp;
  logic        inst_valid;
  logic [15:0] head0;
  logic [15:0] head1;
  logic [2:0]  count;
  logic [3:0]  occupancy;

  assign occupancy = {1'b0, count} + {2'b00, outstanding_q, 1'b0} + 4'd2;
  assign fetch_req = rst && (state_q == ST_RUN) && !bus.redirect
                     && (occupancy <= 4'(QUEUE_DEPTH));
  assign accept    = fetch_req && bus.fetch_gnt;

  assign resp  = bus.fetch_valid && (state_q == ST_RUN) && !bus.redirect;
  assign push2 = resp && !skip_lo_q;
  assign push1 = resp && skip_lo_q;

  assign head_comp  = is_compressed(head0);
  assign inst_valid = (count != 3'd0) && (head_comp || count >= 3'd2);
  assign pop1 = inst_valid && bus.inst_ready && !bus.redirect && head_comp;
  assign pop2 = inst_valid && bus.inst_ready && !bus.redirect && !head_comp;

  halfword_queue u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.redirect),
    .push1   (push1),
    .push2   (push2),
    .pop1    (pop1),
    .pop2    (pop2),
    .push_lo (skip_lo_q ? bus.fetch_data[31:16] : bus.fetch_data[15:0]),
    .push_hi (bus.fetch_data[31:16]),
    .head0   (head0),
    .head1   (head1),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // A response landing in the redirect cycle itself is already discarded,
  // so DROP is entered only when the stale response is still to come.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.redirect && outstanding_q && !bus.fetch_valid) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (bus.redirect) state_d = (outstanding_q && !bus.fetch_valid) ? ST_DROP : ST_RUN;
        else if (bus.fetch_valid) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_addr_q  <= RESET_PC & ~32'h3;
      head_pc_q     <= RESET_PC;
      outstanding_q <= 1'b0;
      skip_lo_q     <= RESET_PC[1];
    end else if (bus.redirect) begin
      fetch_addr_q  <= bus.redirect_pc & ~32'h3;
      head_pc_q     <= bus.redirect_pc & ~32'h1;
      outstanding_q <= outstanding_q && !bus.fetch_valid;
      skip_lo_q     <= bus.redirect_pc[1];
    end else begin
      if (accept) fetch_addr_q <= fetch_addr_q + 32'd4;
      if (pop1)      head_pc_q <= head_pc_q + 32'd2;
      else if (pop2) head_pc_q <= head_pc_q + 32'd4;
      if (accept)               outstanding_q <= 1'b1;
      else if (bus.fetch_valid) outstanding_q <= 1'b0;
      if (resp) skip_lo_q <= 1'b0;
    end
  end

  assign bus.fetch_req       = fetch_req;
  assign bus.fetch_addr      = fetch_addr_q;
  assign bus.inst_valid      = inst_valid;
  assign bus.inst_pc         = head_pc_q;
  assign bus.inst_compressed = inst_valid && head_comp;
  assign bus.inst_data       = !inst_valid ? '0 :
                               head_comp   ? {16'h0000, head0} : {head1, head0};

endmodule

// File: tb/tb_fetch_align_unit.sv
// Bench for fetch_align_unit: single-cycle memory model plus an
// instruction-stream reference that decodes lengths straight from memory.
module tb_fetch_align_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_align_unit_if bus ();

  fetch_align_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        comp;
    int unsigned cyc;
  } rec_t;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned stall    = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] seed;
  logic [31:0] exp_pc;
  logic [31:0] exp_faddr;
  logic        pend;
  logic [31:0] pend_data;
  logic        hold_prev;
  logic [31:0] hold_pc;
  logic [31:0] hold_data;
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  rec_t        log_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (mem.exists(w)) return mem[w];
    w = (w ^ seed) * 32'h9E37_79B1;
    return w ^ (w >> 15);
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: the instruction starting at pc and its length in bytes.
  function automatic logic [31:0] ref_inst(input logic [31:0] pc, output int unsigned len);
    logic [15:0] lo;
    lo = hw_at(pc);
    if (lo[1:0] != 2'b11) begin
      len = 2;
      return {16'h0000, lo};
    end
    len = 4;
    return {hw_at(pc + 32'd2), lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend            = 1'b0;
    pend_data       = '0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;
    exp_pc          = 32'h0;
    exp_faddr       = 32'h0;
    hold_prev       = 1'b0;
    stall           = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick(input logic gnt, input logic rdy, input logic redir, input logic [31:0] rpc);
    int unsigned len;
    logic [31:0] d;
    logic        hs;
    logic        next_pend;
    logic [31:0] next_data;
    len = 0;
    d   = '0;
    bus.fetch_gnt   = gnt;
    bus.inst_ready  = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
    s_req   = bus.fetch_req;
    s_addr  = bus.fetch_addr;
    s_valid = bus.inst_valid;
    if (redir) chk("req_during_redirect", {31'b0, s_req}, 32'd0);
    if (s_req) chk("fetch_addr", s_addr, exp_faddr);
    if (hold_prev) begin
      chk("hold_valid", {31'b0, s_valid}, 32'd1);
      chk("hold_pc", bus.inst_pc, hold_pc);
      chk("hold_data", bus.inst_data, hold_data);
    end
    if (s_valid) begin
      d = ref_inst(exp_pc, len);
      chk("inst_pc", bus.inst_pc, exp_pc);
      chk("inst_data", bus.inst_data, d);
      chk("inst_compressed", {31'b0, bus.inst_compressed}, {31'b0, (len == 2)});
    end
    hs = s_valid && rdy && !redir;
    if (hs) log_q.push_back('{pc: exp_pc, data: d, comp: (len == 2), cyc: cyc});
    hold_prev = s_valid && !rdy && !redir;
    hold_pc   = exp_pc;
    hold_data = d;
    next_pend = s_req && gnt;
    next_data = mem_word(s_addr);
    if (redir) begin
      exp_pc    = rpc & ~32'h1;
      exp_faddr = rpc & ~32'h3;
      stall     = 0;
    end else begin
      if (next_pend) exp_faddr = exp_faddr + 32'd4;
      if (hs) begin
        exp_pc = exp_pc + len;
        stall  = 0;
      end else begin
        stall++;
      end
    end
    if (stall > 60) begin
      chk("progress_timeout", stall, 32'd60);
      stall = 0;
    end
    @(posedge clk);
    @(negedge clk);
    pend            = next_pend;
    pend_data       = next_data;
    bus.fetch_valid = pend;
    bus.fetch_data  = pend ? pend_data : $urandom;
    cyc++;
  endtask

  initial begin
    int unsigned r;
    logic [31:0] bp_pc;
    logic        found;
    logic [31:0] rpc;
    seed = $urandom;
    mem[32'h0]   = 32'h0050_0093;
    mem[32'h4]   = 32'h00A0_0113;
    mem[32'h100] = 32'h0001_FFFF;
    bus.fetch_gnt   = 1'b0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_fetch_req", {31'b0, bus.fetch_req}, 32'd0);
    chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_fetch_addr", bus.fetch_addr, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_compressed", {31'b0, bus.inst_compressed}, 32'd0);

    // Aligned 32-bit stream straight out of reset.
    rst = 1'b1;
    cyc = 0;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("release_req", {31'b0, s_req}, 32'd1);
    chk("release_addr", s_addr, 32'h0);
    repeat (5) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("aligned_count", {31'b0, (log_q.size() >= 2)}, 32'd1);
    if (log_q.size() >= 2) begin
      chk("aligned0_pc", log_q[0].pc, 32'h0);
      chk("aligned0_data", log_q[0].data, 32'h0050_0093);
      chk("aligned0_cyc", log_q[0].cyc, 32'd2);
      chk("aligned1_pc", log_q[1].pc, 32'h4);
      chk("aligned1_data", log_q[1].data, 32'h00A0_0113);
      chk("aligned1_cyc", log_q[1].cyc, 32'd3);
    end

    // Mixed compressed / straddling stream after a redirect to 0.
    log_q.delete();
    r = cyc;
    tick(1'b1, 1'b1, 1'b1, 32'h0);
    mem[32'h0] = 32'h0093_4505;
    mem[32'h4] = 32'h0001_0050;
    repeat (8) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("straddle_count", {31'b0, (log_q.size() >= 3)}, 32'd1);
    if (log_q.size() >= 3) begin
      chk("straddle0_data", log_q[0].data, 32'h0000_4505);
      chk("straddle0_pc", log_q[0].pc, 32'h0);
      chk("straddle0_comp", {31'b0, log_q[0].comp}, 32'd1);
      chk("straddle0_cyc", log_q[0].cyc, r + 3);
      chk("straddle1_data", log_q[1].data, 32'h0050_0093);
      chk("straddle1_pc", log_q[1].pc, 32'h2);
      chk("straddle1_comp", {31'b0, log_q[1].comp}, 32'd0);
      chk("straddle2_data", log_q[2].data, 32'h0000_0001);
      chk("straddle2_pc", log_q[2].pc, 32'h6);
    end

    // Redirect to an odd-halfword target while a response is in flight.
    for (int i = 0; i < 10 && !pend; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("inflight_before_redirect", {31'b0, pend}, 32'd1);
    log_q.delete();
    r = cyc;
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_req", {31'b0, s_req}, 32'd1);
    chk("redir_addr", s_addr, 32'h0000_0100);
    repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_count", {31'b0, (log_q.size() >= 1)}, 32'd1);
    if (log_q.size() >= 1) begin
      chk("redir_first_pc", log_q[0].pc, 32'h0000_0102);
      chk("redir_first_data", log_q[0].data, 32'h0000_0001);
      chk("redir_first_cyc", log_q[0].cyc, r + 3);
    end

    // Backpressure: hold inst_ready low for six cycles.
    repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("bp_req_off", {31'b0, s_req}, 32'd0);
    chk("bp_valid", {31'b0, s_valid}, 32'd1);
    bp_pc = exp_pc;
    log_q.delete();
    repeat (20) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("bp_resume_count", {31'b0, (log_q.size() >= 1)}, 32'd1);
    if (log_q.size() >= 1) chk("bp_resume_pc", log_q[0].pc, bp_pc);

    // PC wrap through 0xFFFF_FFFE -> 0x0.
    log_q.delete();
    tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFA);
    repeat (16) tick(1'b1, 1'b1, 1'b0, 32'h0);
    found = 1'b0;
    foreach (log_q[i]) if (log_q[i].pc < 32'h10) found = 1'b1;
    chk("wrap_seen", {31'b0, found}, 32'd1);
    if (log_q.size() >= 1) chk("wrap_first_pc", log_q[0].pc, 32'hFFFF_FFFA);

    // Asynchronous reset between clock edges.
    repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("arst_fetch_req", {31'b0, bus.fetch_req}, 32'd0);
    chk("arst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("arst_fetch_addr", bus.fetch_addr, 32'h0);
    chk("arst_inst_pc", bus.inst_pc, 32'h0);
    chk("arst_inst_data", bus.inst_data, 32'h0);
    chk("arst_inst_compressed", {31'b0, bus.inst_compressed}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    log_q.delete();
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("arst_release_req", {31'b0, s_req}, 32'd1);
    chk("arst_release_addr", s_addr, 32'h0);
    repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);
    if (log_q.size() >= 1) chk("arst_first_data", log_q[0].data, 32'h0000_4505);
    chk("arst_restart", {31'b0, (log_q.size() >= 1)}, 32'd1);

    // Randomized grants, backpressure and redirects.
    for (int i = 0; i < 1500; i++) begin
      rpc = $urandom_range(0, 1023);
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) < 3, rpc);
    end
    log_q.delete();
    repeat (30) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drain_progress", {31'b0, (log_q.size() >= 1)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
